// File: rtl/bcd_meas_pkg.sv
// Shared types and constants for the BCD measurement sequencer.
package bcd_meas_pkg;

    localparam int unsigned BCD_W = 12;
    localparam logic [BCD_W-1:0] BCD_MAX = 12'h999;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus a third flop for registered rising-edge detection.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
        end
    end

endmodule

// File: rtl/bcd_meas_ctrl.sv
// Gate-window measurement sequencer driving an external 3-digit BCD counter.
// Define BCD_MEAS_AUTO_RESTART_EN for continuous back-to-back measurements.
module bcd_meas_ctrl
    import bcd_meas_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    input  logic [BCD_W-1:0] cnt_q,
    input  logic             cnt_cout,
    output logic             cnt_clr_n,
    output logic             cnt_cin,
    output logic [BCD_W-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_MAX = max_u(GATE_CYCLES, max_u(CLR_CYCLES, SETTLE_CYCLES));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             cnt_zero;
    logic             rise;
    logic             ovf_seen;

    logic             clr_n_d;
    logic             cin_d;
    logic             busy_d;
    logic             done_d;
    logic             ovf_seen_d;
    logic [BCD_W-1:0] result_d;
    logic             overflow_d;

    assign cnt_zero = (cnt == '0);

    sync_edge_det u_sync_edge_det (
        .clk  (clk),
        .rst  (rst),
        .d    (sig_in),
        .rise (rise)
    );

    // State register; phase counter loads on state entry and counts down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= cnt_load;
            end else if (!cnt_zero) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = '0;
        case (state)
            IDLE:    if (start)    next_state = CLEAR;
            CLEAR:   if (cnt_zero) next_state = GATE;
            GATE:    if (cnt_zero) next_state = SETTLE;
            SETTLE:  if (cnt_zero) next_state = LATCH;
`ifdef BCD_MEAS_AUTO_RESTART_EN
            LATCH:   next_state = CLEAR;
`else
            LATCH:   next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
        case (next_state)
            CLEAR:   cnt_load = CNT_W'(CLR_CYCLES - 1);
            GATE:    cnt_load = CNT_W'(GATE_CYCLES - 1);
            SETTLE:  cnt_load = CNT_W'(SETTLE_CYCLES - 1);
            default: cnt_load = '0;
        endcase
    end

    // Next values of the registered outputs; they track next_state so each
    // output is aligned with the state it belongs to.
    always_comb begin
        clr_n_d    = (next_state != CLEAR);
        busy_d     = (next_state != IDLE);
        cin_d      = rise && (state == GATE);
        done_d     = (state == LATCH);
        ovf_seen_d = ovf_seen;
        result_d   = result;
        overflow_d = overflow;
        if (next_state == CLEAR && state != CLEAR) begin
            ovf_seen_d = 1'b0;
        end else if (cnt_cout && (state == GATE || state == SETTLE)) begin
            ovf_seen_d = 1'b1;
        end
        if (state == LATCH) begin
            result_d   = ovf_seen ? BCD_MAX : cnt_q;
            overflow_d = ovf_seen;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_clr_n <= 1'b0;
            cnt_cin   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf_seen  <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            cnt_clr_n <= clr_n_d;
            cnt_cin   <= cin_d;
            busy      <= busy_d;
            done      <= done_d;
            ovf_seen  <= ovf_seen_d;
            result    <= result_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: doc/bcd_meas_ctrl.md
Name: bcd_meas_ctrl

Overview:
Measurement sequencer for the 3-digit BCD counter (`bcdcnt_top`: `cin`, `cout`, `q[11:0]`).
- On `start`, it clears the counter and opens a gate window of fixed length.
- During the gate it forwards synchronized rising edges of an external signal as one-cycle `cin` pulses.
- After the gate closes it waits for the counter to settle, latches the BCD result (saturated on overflow) and reports `done`.
- Sits between the top-level control/display logic and the counter instance.

Parameters:
- GATE_CYCLES, 1000, length of the gate window in clk cycles (≥1).
- CLR_CYCLES, 2, number of cycles `cnt_clr_n` is held low before the gate opens (≥1).
- SETTLE_CYCLES, 2, cycles between gate close and result latch (≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle measurement request; honoured only in IDLE.
- sig_in  input  1  asynchronous signal to be counted.
- cnt_q  input  12  BCD count from counter (hundreds[11:8], tens[7:4], units[3:0]).
- cnt_cout  input  1  counter carry/overflow output.
- cnt_clr_n  output  1  active-low clear to counter.
- cnt_cin  output  1  registered count-enable pulse to counter.
- result  output  12  latched BCD result.
- overflow  output  1  result saturated flag, valid with `result`.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when `result` updates.

Behaviour:
- Reset (`rst`=0, asynchronous) forces all of the following immediately, regardless of state, including mid-GATE:
  - state=IDLE;
  - `cnt_clr_n`=0, `cnt_cin`=0;
  - `result`=12'h000, `overflow`=0, `busy`=0, `done`=0;
  - synchronizer flops=0, gate/phase counters=0.
- After release, `cnt_clr_n`=1 while in IDLE.
- Edge detection on `sig_in`:
  - 2-flop synchronizer followed by a third flop for edge detect; `rise` = sync & ~prev.
  - `cnt_cin` is registered as `rise` & (state==GATE), giving a 1-cycle pulse.
  - Latency from a `sig_in` rising edge to the `cnt_cin` pulse is 3–4 clk cycles.
  - `sig_in` high and low phases must each be ≥2 clk periods for an exact count; narrower pulses may be lost, and this is not flagged.
- States:
  - IDLE: `busy`=0. `start`=1 moves to CLEAR on the next edge.
  - CLEAR: `cnt_clr_n`=0 for exactly CLR_CYCLES cycles, then GATE.
  - GATE: exactly GATE_CYCLES cycles. `cnt_cin` pulses as above. `cnt_cout`=1 in any GATE or SETTLE cycle sets an internal sticky `ovf_seen`.
  - SETTLE: SETTLE_CYCLES cycles with `cnt_cin` forced 0. A pulse generated in the last GATE cycle still lands during this state.
  - LATCH: one cycle.
    - `result` <= `ovf_seen` ? 12'h999 : `cnt_q`.
    - `overflow` <= `ovf_seen`.
    - `done`=1 for this cycle, then IDLE.
- `ovf_seen` is cleared on entry to CLEAR.
- `start` while `busy`=1 is ignored, with no queuing.
- `result` and `overflow` hold their values until the next LATCH.
- Total measurement time from `start` to `done` = 1 + CLR_CYCLES + GATE_CYCLES + SETTLE_CYCLES cycles.
- Gate counter width is $clog2(GATE_CYCLES+1). Counters load in the entry cycle and count down, so there are no off-by-one wraps.

Optional Feature:
- Macro: BCD_MEAS_AUTO_RESTART_EN.
- Defined: LATCH goes directly to CLEAR (continuous measurement).
  - `busy` stays 1 after the first `start`.
  - `done` pulses every measurement period.
  - `start` is a don't-care once running; only `rst` stops the loop.
- Undefined: LATCH returns to IDLE, exactly as described above.

Decomposition:
- Package `bcd_meas_pkg`:
  - state enum (IDLE, CLEAR, GATE, SETTLE, LATCH) with 3-bit encoding;
  - constant BCD_MAX=12'h999;
  - constant BCD_W=12.
- One sub-module `sync_edge_det`: 2-flop synchronizer plus rising-edge detect, ports clk, rst, d, rise.

Test Plan:
- Count: GATE_CYCLES=100, `sig_in` period 4 clk (2 high/2 low), pulse `start` -> `done` after 105 cycles; `result`=12'h025, `overflow`=0.
- Zero input: `sig_in` held 0, `start` -> `result`=12'h000, `overflow`=0, `cnt_cin` never asserted.
- Overflow: GATE_CYCLES=5000, `sig_in` period 4 clk -> counter wraps, `cnt_cout` seen; `result`=12'h999, `overflow`=1.
- Busy lockout: second `start` pulses at cycles 10 and 50 after the first -> exactly one `done`, with `busy` high throughout.
- Reset mid-GATE: drop `rst` 30 cycles into GATE -> same-cycle `cnt_clr_n`=0, `busy`=0, `result`=000; a new `start` after release produces a correct count.
- With BCD_MEAS_AUTO_RESTART_EN, GATE_CYCLES=100, period 4 -> `done` every 105 cycles, each `result`=12'h025.
